// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port 0 has priority; port 1 gets starvation relief and an exclusive lock.
//
// Ports:
//   clk_i, rst_ni       : clock, async active-low reset
//   p0_* / p1_*         : requester ports (req/we/addr/wdata in;
//                         gnt/rvalid/rdata out); p1_lock_i keeps ownership
//   mem_*               : memory drive (we/re/addr/wdata out, rdata in)
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  input  logic              p1_lock_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

  logic p0_win;
  logic p1_win;
  logic starved;

  // Grants are gated by rst_ni so nothing reaches memory during reset.
  always_comb begin
    starved = (wait_cnt_q == MaxWait);
    p0_win  = 1'b0;
    p1_win  = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        ARB: begin
          p1_win = p1_req_i && (!p0_req_i || starved);
          p0_win = p0_req_i && !p1_win;
        end
        LOCK1: begin
          p1_win = p1_req_i;
        end
        default: begin
          p1_win = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (1'b1)
      p1_win: begin
        mem_we_o    = p1_we_i;
        mem_re_o    = !p1_we_i;
        mem_addr_o  = p1_addr_i;
        mem_wdata_o = p1_wdata_i;
      end
      p0_win: begin
        mem_we_o    = p0_we_i;
        mem_re_o    = !p0_we_i;
        mem_addr_o  = p0_addr_i;
        mem_wdata_o = p0_wdata_i;
      end
      default: begin
        mem_we_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (p1_win) begin
      state_d = p1_lock_i ? LOCK1 : ARB;
    end

    wait_cnt_d = '0;
    if (p1_req_i && !p1_win) begin
      wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 4'd1;
    end

    p0_rvalid_d = p0_win && !p0_we_i;
    p1_rvalid_d = p1_win && !p1_we_i;
    p0_rdata_d  = p0_rvalid_d ? mem_rdata_i : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_rdata_i : p1_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB;
      wait_cnt_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign p0_gnt_o    = p0_win;
  assign p1_gnt_o    = p1_win;
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset sequences,
// then random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p1_lock = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_gnt_o(p0_gnt),
    .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_lock_i(p1_lock), .p1_gnt_o(p1_gnt),
    .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h010) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(a);
  endfunction

  // Environment memory seen by the DUT.
  logic [DW-1:0] env_mem [1<<AW];
  always @(posedge clk) if (mem_we) env_mem[mem_addr] <= mem_wdata;
  assign mem_rdata = env_mem[mem_addr];

  // Reference model state.
  bit            m_lock;
  int            m_starve;
  bit            exp_v0, exp_v1;
  logic [DW-1:0] exp_d0, exp_d1;
  logic [DW-1:0] ref_mem [int];

  function automatic logic [DW-1:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic model_reset();
    m_lock = 0; m_starve = 0;
    exp_v0 = 0; exp_v1 = 0; exp_d0 = '0; exp_d1 = '0;
  endtask

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit            r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    bit            r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit            lk;
    bit            chk;
    bit            e0, e1;
  } vec_t;

  // Entered just after a falling edge; leaves just after the next one.
  task automatic apply(input vec_t v, output bit g0, output bit g1);
    bit xw; bit xr; logic [AW-1:0] xa; logic [DW-1:0] xd;
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
    p1_lock = v.lk;
    #1;
    g1 = v.r1 && (m_lock || !v.r0 || m_starve == MW);
    g0 = v.r0 && !m_lock && !g1;
    if (v.chk) begin
      check("tbl_gnt0", p0_gnt, v.e0);
      check("tbl_gnt1", p1_gnt, v.e1);
    end
    xw = g1 ? v.w1 : (g0 ? v.w0 : 1'b0);
    xr = (g0 || g1) && !xw;
    xa = g1 ? v.a1 : (g0 ? v.a0 : '0);
    xd = g1 ? v.d1 : (g0 ? v.d0 : '0);
    check("gnt0", p0_gnt, g0);
    check("gnt1", p1_gnt, g1);
    check("mem_we", mem_we, xw);
    check("mem_re", mem_re, xr);
    check("mem_addr", mem_addr, xa);
    check("mem_wdata", mem_wdata, xd);
    exp_v0 = g0 && !v.w0;
    exp_v1 = g1 && !v.w1;
    if (exp_v0) exp_d0 = ref_rd(int'(v.a0));
    if (exp_v1) exp_d1 = ref_rd(int'(v.a1));
    if (g0 && v.w0) ref_mem[int'(v.a0)] = v.d0;
    if (g1 && v.w1) ref_mem[int'(v.a1)] = v.d1;
    if (g1) m_lock = v.lk;
    if (v.r1 && !g1) m_starve = (m_starve < MW) ? m_starve + 1 : MW;
    else m_starve = 0;
    @(posedge clk); #1;
    check("rvalid0", p0_rvalid, exp_v0);
    check("rvalid1", p1_rvalid, exp_v1);
    check("rdata0", p0_rdata, exp_d0);
    check("rdata1", p1_rdata, exp_d1);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input bit r0, w0, input int a0,
                              input logic [DW-1:0] d0,
                              input bit r1, w1, input int a1,
                              input logic [DW-1:0] d1,
                              input bit lk, e0, e1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
    v.lk = lk; v.chk = 1; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit g0, g1;
    vec_t v, q0, q1;
    bit pend0, pend1;

    for (int i = 0; i < (1 << AW); i++) env_mem[i] = init_val(i);
    model_reset();

    // Reset state, with requests present.
    p0_req = 1; p1_req = 1;
    #2;
    check("rst_gnt0", p0_gnt, 0);
    check("rst_gnt1", p1_gnt, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rvalid0", p0_rvalid, 0);
    check("rst_rdata1", p1_rdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Solo read, idle, write then read.
    tbl.push_back(mk(1,0,'h010,0, 0,0,0,0, 0, 1,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,'hFFF,32'h12345678, 0, 0,1));
    tbl.push_back(mk(0,0,0,0, 1,0,'hFFF,0, 0, 0,1));
    // Starvation: 4 port-0 grants then port 1, twice.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++)
        tbl.push_back(mk(1,0,1,0, 1,0,2,0, 0, 1,0));
      tbl.push_back(mk(1,0,1,0, 1,0,2,0, 0, 0,1));
    end
    // Lock: lock=1 (alone), lock=1, idle in lock, lock=0, then port 0.
    tbl.push_back(mk(0,0,0,0, 1,1,5,32'hAAAA5555, 1, 0,1));
    tbl.push_back(mk(1,0,3,0, 1,0,5,0, 1, 0,1));
    tbl.push_back(mk(1,0,3,0, 0,0,0,0, 0, 0,0));
    tbl.push_back(mk(1,0,3,0, 1,0,'hFFF,0, 0, 0,1));
    tbl.push_back(mk(1,0,3,0, 0,0,0,0, 0, 1,0));
    // Idle: rdata holds.
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0, 0,0));

    foreach (tbl[i]) apply(tbl[i], g0, g1);

    // Reset while locked with a port-1 read on the bus.
    apply(mk(0,0,0,0, 1,0,'h010,0, 1, 0,1), g0, g1);
    p0_req = 1; p0_we = 0; p0_addr = 'h003;
    p1_req = 1; p1_we = 0; p1_addr = 'hFFF; p1_lock = 1;
    #1;
    check("lock_gnt0", p0_gnt, 0);
    check("lock_gnt1", p1_gnt, 1);
    #1 rst_n = 0;
    #1;
    check("mrst_gnt1", p1_gnt, 0);
    check("mrst_mem_re", mem_re, 0);
    check("mrst_mem_addr", mem_addr, 0);
    check("mrst_rdata0", p0_rdata, 0);
    @(posedge clk); #1;
    check("mrst_rvalid1", p1_rvalid, 0);
    check("mrst_rdata1", p1_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    apply(mk(1,0,'h010,0, 0,0,0,0, 0, 1,0), g0, g1);

    // Random traffic; requesters hold their request until granted.
    pend0 = 0; pend1 = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend0) begin
        q0.r0 = ($urandom_range(0, 3) != 0);
        q0.w0 = $urandom_range(0, 1);
        q0.a0 = AW'($urandom_range(0, 15));
        q0.d0 = $urandom;
      end
      if (!pend1) begin
        q1.r1 = ($urandom_range(0, 2) == 0);
        q1.w1 = $urandom_range(0, 1);
        q1.a1 = AW'($urandom_range(0, 15));
        q1.d1 = $urandom;
        q1.lk = ($urandom_range(0, 3) == 0);
      end
      v = q0;
      v.r1 = q1.r1; v.w1 = q1.w1; v.a1 = q1.a1;
      v.d1 = q1.d1; v.lk = q1.lk;
      v.chk = 0; v.e0 = 0; v.e1 = 0;
      apply(v, g0, g1);
      pend0 = v.r0 && !g0;
      pend1 = v.r1 && !g1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
